// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - Host-side command handshake bundle for the PS/2 host transmitter
//
// Signals:
//   tx_data  : byte to send, sampled when tx_start is accepted
//   tx_start : single-cycle send request
//   tx_busy  : transmitter owns the PS/2 lines (receive path should ignore traffic)
//   tx_done  : one-cycle pulse, byte sent and acknowledged by the device
//   tx_err   : one-cycle pulse, no acknowledge or timeout
// Modports: master = command issuer, slave = transmitter.
`timescale 1ns/1ps
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (output tx_data, output tx_start,
                    input  tx_busy, input  tx_done, input tx_err);
    modport slave  (input  tx_data, input  tx_start,
                    output tx_busy, output tx_done, output tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - Host-to-device PS/2 byte transmitter with request-to-send and ack check
//
// Ports:
//   clk_i          : board clock, the only clock
//   rst_n_i        : asynchronous active-low reset
//   tx             : command handshake (ps2_host_tx_if.slave)
//   ps2_clk_i      : raw PS/2 clock line
//   ps2_data_i     : raw PS/2 data line
//   ps2_clk_oe_o   : 1 = pull PS/2 clock low
//   ps2_data_oe_o  : 1 = pull PS/2 data low
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    ps2_host_tx_if.slave       tx,
    input  logic               ps2_clk_i,
    input  logic               ps2_data_i,
    output logic               ps2_clk_oe_o,
    output logic               ps2_data_oe_o
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               data_oe_q, data_oe_d;
    logic [10:0]        frame_q, frame_d;

    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic data_s1_q, data_s2_q;

    logic fall;
    logic timeout;
    logic inhibit_last;
    logic timed_state;

    // Synchronizers idle high so reset never looks like a falling edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_i;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= ps2_data_i;
            data_s2_q <= data_s1_q;
        end
    end

    assign fall         = clk_s3_q & ~clk_s2_q;
    assign inhibit_last = (cnt_q == CNT_W'(INHIBIT_CYCLES - 1));
    assign timed_state  = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                          (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    // Timeout is checked before any edge handling, so it wins a same-cycle tie.
    assign timeout      = timed_state && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_oe_q <= 1'b0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_oe_q <= data_oe_d;
            frame_q   <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (tx.tx_start) state_d = S_INHIBIT;
            S_INHIBIT:   if (inhibit_last) state_d = S_REQ;
            S_REQ:       state_d = timeout ? S_ERR : S_SHIFT;
            S_SHIFT: begin
                if (timeout)                        state_d = S_ERR;
                else if (fall && bit_cnt_q == 4'd9) state_d = S_ACK;
            end
            S_ACK: begin
                if (timeout)   state_d = S_ERR;
                else if (fall) state_d = data_s2_q ? S_ERR : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (timeout)                    state_d = S_ERR;
                else if (clk_s2_q && data_s2_q) state_d = S_DONE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_oe_d = data_oe_q;
        frame_d   = frame_q;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                data_oe_d = 1'b0;
                // Frame bit n is what the line carries after falling edge n; bit 10 is the released stop.
                if (tx.tx_start) frame_d = {1'b1, ~^tx.tx_data, tx.tx_data, 1'b0};
            end
            S_INHIBIT: begin
                if (inhibit_last) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REQ: begin
                cnt_d     = cnt_q + CNT_W'(1);
                bit_cnt_d = '0;
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    data_oe_d = ~frame_q[bit_cnt_q + 4'd1];
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall) bit_cnt_d = 4'd11;
            end
            S_WAIT_IDLE: cnt_d = cnt_q + CNT_W'(1);
            default: begin
                cnt_d     = '0;
                data_oe_d = 1'b0;
            end
        endcase
        if (state_d == S_ERR) data_oe_d = 1'b0;
    end

    // Start bit is asserted combinationally in the last inhibit cycle so data is low before clock release.
    always_comb begin
        ps2_clk_oe_o  = (state_q == S_INHIBIT);
        ps2_data_oe_o = (data_oe_q && timed_state) ||
                        ((state_q == S_INHIBIT) && inhibit_last);
        tx.tx_busy    = (state_q != S_IDLE);
        tx.tx_done    = (state_q == S_DONE);
        tx.tx_err     = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TO  = 1500;
    localparam int H   = 20;
    localparam int OUT_DONE = 1;
    localparam int OUT_ERR  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic dev_clk_pull  = 1'b0;
    logic dev_data_pull = 1'b0;
    wire  clk_oe;
    wire  data_oe;
    wire  ps2_clk_line  = ~(clk_oe  | dev_clk_pull);
    wire  ps2_data_line = ~(data_oe | dev_data_pull);

    ps2_host_tx_if tx_if();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .tx           (tx_if),
        .ps2_clk_i    (ps2_clk_line),
        .ps2_data_i   (ps2_data_line),
        .ps2_clk_oe_o (clk_oe),
        .ps2_data_oe_o(data_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_total = 0;
    int err_total  = 0;

    logic [7:0] exp_q[$];
    int         out_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_if.tx_done) done_total <= done_total + 1;
        if (tx_if.tx_err)  err_total  <= err_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d, input int outcome);
        @(negedge clk);
        tx_if.tx_data  = d;
        tx_if.tx_start = 1'b1;
        exp_q.push_back(d);
        out_q.push_back(outcome);
        @(posedge clk);
        #1;
        check_eq("accept_busy", tx_if.tx_busy, 1);
        check_eq("accept_clk_oe", clk_oe, 1);
        @(negedge clk);
        tx_if.tx_start = 1'b0;
        tx_if.tx_data  = ~d;
    endtask

    task automatic measure_inhibit(output int rel);
        int n;
        logic first_doe, last_doe;
        n = 0;
        first_doe = data_oe;
        last_doe  = 1'b0;
        while (clk_oe && n < INH + 100) begin
            last_doe = data_oe;
            n++;
            @(negedge clk);
        end
        check_eq("inhibit_len", n, INH);
        check_eq("data_oe_early", first_doe, 0);
        check_eq("data_oe_last_inhibit", last_doe, 1);
        check_eq("data_oe_at_release", data_oe, 1);
        rel = cyc;
    endtask

    // Device clocks the frame; data is read on each rising edge. abort_at stops after that falling edge.
    task automatic device_frame(input bit ack, input int abort_at, input bit inject, output logic [10:0] bits);
        bits = '0;
        repeat (5) @(negedge clk);
        bits[0] = ps2_data_line;
        for (int n = 1; n <= 11; n++) begin
            dev_clk_pull = 1'b1;
            if (n == abort_at) begin
                repeat (4) @(negedge clk);
                return;
            end
            if (n == 11 && !ack) return;
            if (inject && n == 3) begin
                @(negedge clk);
                tx_if.tx_start = 1'b1;
                tx_if.tx_data  = 8'h5A;
                @(negedge clk);
                tx_if.tx_start = 1'b0;
                repeat (H - 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            if (n <= 10) bits[n] = ps2_data_line;
            dev_clk_pull = 1'b0;
            if (n == 10) dev_data_pull = ack;
            if (n == 11) begin
                dev_data_pull = 1'b0;
                return;
            end
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic wait_result(input logic [10:0] bits, input bit clocked, input int bound, output int at_cyc);
        logic [7:0] eb;
        int eo, n, got;
        eb = exp_q.pop_front();
        eo = out_q.pop_front();
        if (clocked) begin
            check_eq("start_bit", bits[0], 0);
            check_eq("data_byte", bits[8:1], eb);
            check_eq("parity_bit", bits[9], ~^eb);
            check_eq("stop_bit", bits[10], 1);
        end
        n = 0;
        while (!(tx_if.tx_done || tx_if.tx_err) && n < bound) begin
            n++;
            @(negedge clk);
        end
        at_cyc = cyc;
        got = tx_if.tx_done ? OUT_DONE : (tx_if.tx_err ? OUT_ERR : 0);
        check_eq("outcome", got, eo);
        check_eq("pulse_exclusive", tx_if.tx_done & tx_if.tx_err, 0);
        check_eq("busy_at_pulse", tx_if.tx_busy, 1);
        check_eq("oe_released_at_pulse", {clk_oe, data_oe}, 0);
        @(negedge clk);
        check_eq("pulse_one_cycle", {tx_if.tx_done, tx_if.tx_err}, 0);
        check_eq("busy_after_pulse", tx_if.tx_busy, 0);
    endtask

    initial begin
        logic [7:0]  bytes[4];
        logic [10:0] bits;
        int rel, at, d0, e0;

        tx_if.tx_start = 1'b0;
        tx_if.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", tx_if.tx_busy, 0);
        check_eq("rst_oe", {clk_oe, data_oe}, 0);
        check_eq("rst_pulses", {tx_if.tx_done, tx_if.tx_err}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_oe", {clk_oe, data_oe}, 0);

        bytes[0] = 8'hED; bytes[1] = 8'hF4; bytes[2] = 8'h00; bytes[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            start_tx(bytes[i], OUT_DONE);
            measure_inhibit(rel);
            device_frame(1'b1, 0, 1'b0, bits);
            wait_result(bits, 1'b1, 200, at);
            repeat (10) @(negedge clk);
        end

        // Device leaves data high on the ack edge.
        start_tx(8'hA5, OUT_ERR);
        measure_inhibit(rel);
        device_frame(1'b0, 0, 1'b0, bits);
        wait_result(bits, 1'b1, 50, at);
        dev_clk_pull = 1'b0;
        repeat (30) @(negedge clk);

        // Device never clocks.
        start_tx(8'h3C, OUT_ERR);
        measure_inhibit(rel);
        wait_result(bits, 1'b0, TO + 100, at);
        check_eq("timeout_latency", at - rel, TO);
        repeat (10) @(negedge clk);

        // Second request during a frame must be ignored.
        d0 = done_total;
        start_tx(8'h12, OUT_DONE);
        measure_inhibit(rel);
        device_frame(1'b1, 0, 1'b1, bits);
        wait_result(bits, 1'b1, 200, at);
        repeat (20) @(negedge clk);
        check_eq("single_done", done_total - d0, 1);
        check_eq("no_requeue", tx_if.tx_busy, 0);

        // Reset mid-frame after falling edge 5.
        start_tx(8'h00, OUT_DONE);
        measure_inhibit(rel);
        device_frame(1'b1, 5, 1'b0, bits);
        check_eq("pre_reset_data_oe", data_oe, 1);
        e0 = done_total + err_total;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_oe", {clk_oe, data_oe}, 0);
        check_eq("async_rst_busy", tx_if.tx_busy, 0);
        void'(exp_q.pop_front());
        void'(out_q.pop_front());
        dev_clk_pull = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("no_pulse_on_reset", done_total + err_total, e0);
        start_tx(8'hFF, OUT_DONE);
        measure_inhibit(rel);
        device_frame(1'b1, 0, 1'b0, bits);
        wait_result(bits, 1'b1, 200, at);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
